axis_frame_gen: RTL and testbench

- Synthesizable, parametrised AXI4-Stream video frame source. Drives FAST_AXI and any later stream stage on-chip or in simulation.
- Emits width×height pixel frames with TUSER on the first pixel of each frame and TLAST on the last pixel of each line.
- Inserts pseudo-random TVALID gaps from an LFSR to stress downstream back-pressure and stall handling.
- Supports selectable test patterns, a configurable frame count, and abort.

---
 rtl/axis_frame_gen_if.sv | 23 ++
 rtl/axis_frame_gen.sv | 234 +++++++++++++++++++++++
 tb/tb_axis_frame_gen.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_frame_gen_if.sv
// AXI4-Stream video beat bundle between the frame source and its consumer.
// Ports: TDATA_out/TSTRB_out/TVALID_out/TLAST_out/TUSER_out flow from the
// source (master) to the sink (slave); TREADY_in flows back from the sink.
interface axis_frame_gen_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] TDATA_out;
  logic                  TSTRB_out;
  logic                  TVALID_out;
  logic                  TLAST_out;
  logic                  TUSER_out;
  logic                  TREADY_in;

  modport master (
    output TDATA_out, TSTRB_out, TVALID_out, TLAST_out, TUSER_out,
    input  TREADY_in
  );

  modport slave (
    input  TDATA_out, TSTRB_out, TVALID_out, TLAST_out, TUSER_out,
    output TREADY_in
  );
endinterface

// File: rtl/axis_frame_gen.sv
// AXI4-Stream test-pattern frame source with LFSR-driven TVALID gaps.
// Ports: ACLK_in/ARESET_in (sync, active-high); start/abort control; config
// (width/height/frames/mode/const latched at start, gap_en live); axis master
// beat bundle; busy_out level and done_out one-cycle end-of-sequence pulse.
module axis_frame_gen #(
  parameter int          DATA_WIDTH = 8,
  parameter int          DIM_WIDTH  = 11,
  parameter int          RUN_LOG2   = 9,
  parameter int          PAUSE_LOG2 = 3,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  ACLK_in,
  input  logic                  ARESET_in,
  input  logic                  start_in,
  input  logic                  abort_in,
  input  logic [DIM_WIDTH-1:0]  width_in,
  input  logic [DIM_WIDTH-1:0]  height_in,
  input  logic [7:0]            frames_in,
  input  logic [1:0]            mode_in,
  input  logic [DATA_WIDTH-1:0] const_in,
  input  logic                  gap_en,
  axis_frame_gen_if.master      axis,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam int RUN_W = RUN_LOG2 + 1;
  localparam int GAP_W = PAUSE_LOG2 + 1;
  localparam logic [DIM_WIDTH-1:0] DIM_ONE = DIM_WIDTH'(1);
  localparam logic [RUN_W-1:0]     RUN_ONE = RUN_W'(1);
  localparam logic [GAP_W-1:0]     GAP_ONE = GAP_W'(1);

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  state_t state, state_nx;

  logic [DIM_WIDTH-1:0]  width_r, height_r;
  logic [7:0]            frames_r;
  logic [1:0]            mode_r;
  logic [DATA_WIDTH-1:0] const_r;

  logic [DIM_WIDTH-1:0]  x, y, x_nx, y_nx;
  logic [7:0]            frame, frame_nx;
  logic [15:0]           gap_lfsr, pix_lfsr, pix_nx;
  logic [RUN_W-1:0]      run_cnt, run_reload;
  logic [GAP_W-1:0]      gap_cnt, gap_load;

  logic [DATA_WIDTH-1:0] pixel_q;
  logic                  last_q, user_q;
  logic                  done_q, done_nx;
  logic                  abort_pend;

  logic hs, x_end, y_end, seq_end, abort_now, start_ok;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    // x^16 + x^14 + x^13 + x^11 + 1, shifting towards the MSB
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pattern(
    input logic [1:0]            m,
    input logic [DIM_WIDTH-1:0]  px,
    input logic [DIM_WIDTH-1:0]  py,
    input logic [15:0]           l,
    input logic [DATA_WIDTH-1:0] c
  );
    logic [DIM_WIDTH:0]    sum;
    logic [DATA_WIDTH-1:0] res;
    sum = {1'b0, px} + {1'b0, py};
    case (m)
      2'd0:    res = DATA_WIDTH'(sum);
      2'd1:    res = (px[3] ^ py[3]) ? '1 : '0;
      2'd2:    res = c;
      default: res = l[DATA_WIDTH-1:0];
    endcase
    return res;
  endfunction

  assign hs         = (state == ACTIVE) && axis.TREADY_in;
  assign x_end      = (x == width_r - DIM_ONE);
  assign y_end      = (y == height_r - DIM_ONE);
  assign seq_end    = x_end && y_end && (frames_r != 8'd0) && (frame == frames_r - 8'd1);
  // An abort seen while stalled is remembered until the beat is accepted.
  assign abort_now  = abort_in || abort_pend;
  assign start_ok   = start_in && (width_in != '0) && (height_in != '0);
  assign run_reload = {1'b0, gap_lfsr[RUN_LOG2-1:0]} + RUN_ONE;
  assign gap_load   = {1'b0, gap_lfsr[PAUSE_LOG2-1:0]} + GAP_ONE;

  // Coordinates and pixel-LFSR state of the beat following the current one.
  always_comb begin
    x_nx     = x + DIM_ONE;
    y_nx     = y;
    frame_nx = frame;
    pix_nx   = lfsr_next(pix_lfsr);
    if (x_end) begin
      x_nx = '0;
      y_nx = y + DIM_ONE;
      if (y_end) begin
        y_nx     = '0;
        frame_nx = frame + 8'd1;
        pix_nx   = LFSR_SEED;  // each frame replays the same pseudo-random data
      end
    end
  end

  always_ff @(posedge ACLK_in) begin
    if (ARESET_in) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) state_nx = ACTIVE;
      end
      ACTIVE: begin
        if (hs) begin
          if (seq_end || abort_now) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else if ((run_cnt == RUN_ONE) && gap_en) begin
            state_nx = GAP;
          end
        end
      end
      GAP: begin
        if (abort_now) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else if (gap_cnt == GAP_ONE) begin
          state_nx = ACTIVE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ACLK_in) begin
    if (ARESET_in) begin
      width_r    <= '0;
      height_r   <= '0;
      frames_r   <= '0;
      mode_r     <= '0;
      const_r    <= '0;
      x          <= '0;
      y          <= '0;
      frame      <= '0;
      gap_lfsr   <= LFSR_SEED;
      pix_lfsr   <= LFSR_SEED;
      run_cnt    <= '0;
      gap_cnt    <= '0;
      pixel_q    <= '0;
      last_q     <= 1'b0;
      user_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      done_q <= done_nx;

      if (state != IDLE) gap_lfsr <= lfsr_next(gap_lfsr);

      if (state_nx == IDLE)                  abort_pend <= 1'b0;
      else if (abort_in && (state != IDLE))  abort_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (start_ok) begin
            width_r  <= width_in;
            height_r <= height_in;
            frames_r <= frames_in;
            mode_r   <= mode_in;
            const_r  <= const_in;
            x        <= '0;
            y        <= '0;
            frame    <= '0;
            pix_lfsr <= LFSR_SEED;
            run_cnt  <= run_reload;
            pixel_q  <= pattern(mode_in, '0, '0, LFSR_SEED, const_in);
            last_q   <= (width_in == DIM_ONE);
            user_q   <= 1'b1;
          end
        end
        ACTIVE: begin
          if (hs) begin
            if (state_nx == IDLE) begin
              pixel_q <= '0;
              last_q  <= 1'b0;
              user_q  <= 1'b0;
            end else begin
              x        <= x_nx;
              y        <= y_nx;
              frame    <= frame_nx;
              pix_lfsr <= pix_nx;
              pixel_q  <= pattern(mode_r, x_nx, y_nx, pix_nx, const_r);
              last_q   <= (x_nx == width_r - DIM_ONE);
              user_q   <= (x_nx == '0) && (y_nx == '0);
              if (state_nx == GAP) begin
                run_cnt <= '0;
                gap_cnt <= gap_load;
              end else if (run_cnt == RUN_ONE) begin
                run_cnt <= run_reload;  // run expired with gaps disabled
              end else begin
                run_cnt <= run_cnt - RUN_ONE;
              end
            end
          end
        end
        GAP: begin
          if (state_nx == IDLE) begin
            pixel_q <= '0;
            last_q  <= 1'b0;
            user_q  <= 1'b0;
          end else if (state_nx == ACTIVE) begin
            run_cnt <= run_reload;
          end else begin
            gap_cnt <= gap_cnt - GAP_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign axis.TVALID_out = (state == ACTIVE);
  assign axis.TSTRB_out  = (state == ACTIVE);
  assign axis.TDATA_out  = pixel_q;
  assign axis.TLAST_out  = last_q;
  assign axis.TUSER_out  = user_q;
  assign busy_out        = (state != IDLE);
  assign done_out        = done_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
module tb_axis_frame_gen;
  localparam int          DW   = 8;
  localparam int          DIMW = 11;
  localparam logic [15:0] SEED = 16'hACE1;

  logic            ACLK_in = 1'b0;
  logic            ARESET_in, start_in, abort_in, gap_en, busy_out, done_out;
  logic [DIMW-1:0] width_in, height_in;
  logic [7:0]      frames_in;
  logic [1:0]      mode_in;
  logic [DW-1:0]   const_in;

  axis_frame_gen_if #(.DATA_WIDTH(DW)) axis ();

  axis_frame_gen #(
    .DATA_WIDTH(DW), .DIM_WIDTH(DIMW), .RUN_LOG2(9), .PAUSE_LOG2(3), .LFSR_SEED(SEED)
  ) dut (
    .ACLK_in   (ACLK_in),
    .ARESET_in (ARESET_in),
    .start_in  (start_in),
    .abort_in  (abort_in),
    .width_in  (width_in),
    .height_in (height_in),
    .frames_in (frames_in),
    .mode_in   (mode_in),
    .const_in  (const_in),
    .gap_en    (gap_en),
    .axis      (axis.master),
    .busy_out  (busy_out),
    .done_out  (done_out)
  );

  always #5 ACLK_in = ~ACLK_in;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  typedef struct packed {
    logic          strb;
    logic [DW-1:0] d;
    logic          last;
    logic          user;
  } beat_t;

  beat_t exp_q[$];

  // Reference beat list for a whole sequence, straight from the pattern rules.
  task automatic build(input int w, input int h, input int nf, input int mode, input logic [DW-1:0] c);
    logic [15:0] l;
    beat_t       b;
    exp_q.delete();
    for (int f = 0; f < nf; f++) begin
      l = SEED;
      for (int yy = 0; yy < h; yy++) begin
        for (int xx = 0; xx < w; xx++) begin
          case (mode)
            0:       b.d = DW'(xx + yy);
            1:       b.d = (((xx >> 3) ^ (yy >> 3)) & 1) != 0 ? '1 : '0;
            2:       b.d = c;
            default: b.d = l[DW-1:0];
          endcase
          b.strb = 1'b1;
          b.last = (xx == w - 1);
          b.user = (xx == 0) && (yy == 0);
          exp_q.push_back(b);
          l = lfsr_step(l);
        end
      end
    end
  endtask

  // rmode: 0 ready always, 1 ready toggles 1010..., 2 random ready.
  task automatic run_seq(input string tag, input int w, input int h, input int nf, input int mode,
                         input logic [DW-1:0] c, input logic gp, input int rmode, input int restart_at);
    int          idx, cyc, hs_cyc, done_cyc, gap_len, nuser, nlast, budget;
    logic        done_seen, stalled, restarted, rdy, same;
    beat_t       cur, held;
    logic [DW-1:0] obs_q[$];
    build(w, h, nf, mode, c);
    budget    = 30 * exp_q.size() + 200;
    width_in  = DIMW'(w);
    height_in = DIMW'(h);
    frames_in = 8'(nf);
    mode_in   = 2'(mode);
    const_in  = c;
    gap_en    = gp;
    start_in  = 1'b1;
    @(negedge ACLK_in);
    start_in = 1'b0;
    check({tag, "_first_valid"}, axis.TVALID_out, 1'b1);
    idx = 0; cyc = 0; hs_cyc = 0; done_cyc = 0; gap_len = 0; nuser = 0; nlast = 0;
    done_seen = 1'b0; stalled = 1'b0; restarted = 1'b0; held = '0;
    while (cyc < budget) begin
      start_in = 1'b0;
      if (done_out) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
        break;
      end
      cur = {axis.TSTRB_out, axis.TDATA_out, axis.TLAST_out, axis.TUSER_out};
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      axis.TREADY_in = rdy;
      if (axis.TVALID_out) begin
        if (gap_len > 0) begin
          check({tag, "_gap_le_8"}, 32'(gap_len <= 8), 1);
          gap_len = 0;
        end
        if (stalled) check({tag, "_stall_hold"}, 32'(cur), 32'(held));
        if (restart_at == idx && !restarted) begin
          restarted = 1'b1;
          start_in  = 1'b1;
          width_in  = 2;
          height_in = 1;
          mode_in   = 2;
          frames_in = 0;
        end
        if (rdy) begin
          if (idx < exp_q.size()) check({tag, "_beat"}, 32'(cur), 32'(exp_q[idx]));
          else                    check({tag, "_extra_beat"}, idx, exp_q.size());
          obs_q.push_back(cur.d);
          nuser += int'(cur.user);
          nlast += int'(cur.last);
          idx++;
          hs_cyc  = cyc;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = cur;
        end
      end else begin
        if (stalled) begin
          check({tag, "_valid_held"}, axis.TVALID_out, 1'b1);
          stalled = 1'b0;
        end
        if (busy_out) begin
          gap_len++;
          if (!gp) check({tag, "_no_gap"}, axis.TVALID_out, 1'b1);
        end
      end
      @(negedge ACLK_in);
      cyc++;
    end
    start_in       = 1'b0;
    axis.TREADY_in = 1'b0;
    check({tag, "_done_seen"}, done_seen, 1'b1);
    check({tag, "_handshakes"}, idx, exp_q.size());
    check({tag, "_done_latency"}, done_cyc - hs_cyc, 1);
    check({tag, "_idle_at_done"}, {busy_out, axis.TVALID_out}, 2'b00);
    check({tag, "_tuser_count"}, nuser, nf);
    check({tag, "_tlast_count"}, nlast, nf * h);
    if (nf == 2 && obs_q.size() == exp_q.size()) begin
      same = 1'b1;
      for (int i = 0; i < obs_q.size() / 2; i++)
        if (obs_q[i] !== obs_q[i + obs_q.size() / 2]) same = 1'b0;
      check({tag, "_frame_repeat"}, same, 1'b1);
    end
    @(negedge ACLK_in);
    check({tag, "_done_single"}, done_out, 1'b0);
  endtask

  logic found;

  initial begin
    ARESET_in = 1'b1; start_in = 1'b0; abort_in = 1'b0; gap_en = 1'b0;
    width_in = '0; height_in = '0; frames_in = '0; mode_in = '0; const_in = '0;
    axis.TREADY_in = 1'b0;
    repeat (3) @(negedge ACLK_in);
    check("reset_ctrl", {axis.TVALID_out, axis.TSTRB_out, axis.TLAST_out, axis.TUSER_out, busy_out, done_out}, 6'b0);
    check("reset_data", axis.TDATA_out, '0);
    ARESET_in = 1'b0;
    @(negedge ACLK_in);

    run_seq("ramp",         4,  3, 1, 0, 8'h00, 1'b0, 0, -1);
    run_seq("ramp_toggle",  4,  3, 1, 0, 8'h00, 1'b0, 1, -1);
    run_seq("rand_frames", 16,  6, 2, 3, 8'h00, 1'b1, 2, -1);
    run_seq("const_w1",     1,  5, 1, 2, 8'h5A, 1'b0, 0, -1);
    run_seq("checker",     20, 18, 1, 1, 8'h00, 1'b1, 2, -1);
    run_seq("busy_restart", 4,  3, 1, 0, 8'h00, 1'b0, 0,  2);

    // Zero-sized starts are ignored.
    width_in = 0; height_in = 3; frames_in = 1; start_in = 1'b1;
    @(negedge ACLK_in);
    start_in = 1'b0;
    check("zero_width_idle", {busy_out, axis.TVALID_out, done_out}, 3'b000);
    width_in = 3; height_in = 0; start_in = 1'b1;
    @(negedge ACLK_in);
    start_in = 1'b0;
    check("zero_height_idle", {busy_out, axis.TVALID_out, done_out}, 3'b000);
    @(negedge ACLK_in);
    check("zero_size_no_done", done_out, 1'b0);

    // Abort while stalled: the pending beat must still be delivered.
    width_in = 8; height_in = 4; frames_in = 0; mode_in = 0; gap_en = 1'b0;
    axis.TREADY_in = 1'b1; start_in = 1'b1;
    @(negedge ACLK_in);
    start_in = 1'b0;
    repeat (5) @(negedge ACLK_in);
    check("abort_pre_beat", {axis.TSTRB_out, axis.TDATA_out, axis.TLAST_out, axis.TUSER_out},
          {1'b1, 8'd5, 1'b0, 1'b0});
    axis.TREADY_in = 1'b0;
    abort_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK_in);
      check("abort_stall_valid", axis.TVALID_out, 1'b1);
      check("abort_stall_data", axis.TDATA_out, 8'd5);
    end
    axis.TREADY_in = 1'b1;
    @(negedge ACLK_in);
    check("abort_idle", {busy_out, axis.TVALID_out, done_out}, 3'b001);
    abort_in = 1'b0;
    axis.TREADY_in = 1'b0;
    @(negedge ACLK_in);
    check("abort_done_once", done_out, 1'b0);

    // Abort during a gap.
    gap_en = 1'b1; axis.TREADY_in = 1'b1; start_in = 1'b1;
    @(negedge ACLK_in);
    start_in = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      if (busy_out && !axis.TVALID_out) found = 1'b1;
      else @(negedge ACLK_in);
    end
    check("gap_reached", found, 1'b1);
    abort_in = 1'b1;
    @(negedge ACLK_in);
    abort_in = 1'b0;
    check("gap_abort_idle", {busy_out, axis.TVALID_out, done_out}, 3'b001);
    @(negedge ACLK_in);
    check("gap_abort_done_once", done_out, 1'b0);

    // Reset in the middle of a line.
    gap_en = 1'b0; frames_in = 1; axis.TREADY_in = 1'b1; start_in = 1'b1;
    @(negedge ACLK_in);
    start_in = 1'b0;
    repeat (3) @(negedge ACLK_in);
    check("midline_active", axis.TVALID_out, 1'b1);
    ARESET_in = 1'b1;
    @(negedge ACLK_in);
    check("midreset_ctrl", {axis.TVALID_out, axis.TSTRB_out, axis.TLAST_out, axis.TUSER_out, busy_out, done_out}, 6'b0);
    check("midreset_data", axis.TDATA_out, '0);
    ARESET_in = 1'b0;
    @(negedge ACLK_in);
    check("post_reset_idle", {busy_out, done_out}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
